load_store_unit: RTL and testbench

Byte-serial load/store unit between the core's execute stage and the byte-wide data memory. It takes a load or store request with a RISC-V funct3 size code and moves one byte per cycle over an 8-bit memory port, little-endian. Store data comes from the register file's RD2. Load results are sign- or zero-extended, assembled to 32 bits and returned as the WD3 writeback value.

---
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: moves 1/2/4 bytes little-endian over an 8-bit
// memory port, one byte per cycle, and returns sign/zero-extended load data.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

  state_t                   r_state, w_next;
  logic                     r_we;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [1:0]               r_cnt;
  logic [DATA_WIDTH-1:0]    r_asm;
  logic                     r_err;

  logic                     w_legal;
  logic [1:0]               w_last_cnt;
  logic [DATA_WIDTH-1:0]    w_ext;

  // Size/alignment legality of the incoming request; stores have no unsigned forms.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: w_legal = ~addr[0];
      3'b010:         w_legal = (addr[1:0] == 2'b00);
      default:        w_legal = 1'b0;
    endcase
    if (req_we && funct3[2]) w_legal = 1'b0;
  end

  always_comb begin
    w_last_cnt = 2'd0;
    if (r_funct3[1])      w_last_cnt = 2'd3;
    else if (r_funct3[0]) w_last_cnt = 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_legal ? S_XFER : S_RESP;
      S_XFER: if (r_cnt == w_last_cnt) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= 2'd0;
      r_asm    <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_funct3 <= funct3;
          r_addr   <= addr;
          r_wdata  <= wdata;
          r_cnt    <= 2'd0;
          r_asm    <= '0;
          r_err    <= ~w_legal;
        end
        S_XFER: begin
          if (!r_we) r_asm[{r_cnt, 3'b000} +: 8] <= mem_rdata;
          r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{r_asm[7]}},  r_asm[7:0]};
      3'b001:  w_ext = {{16{r_asm[15]}}, r_asm[15:0]};
      3'b100:  w_ext = {24'd0, r_asm[7:0]};
      3'b101:  w_ext = {16'd0, r_asm[15:0]};
      default: w_ext = r_asm;
    endcase
  end

  // All outputs are decoded from registered state; nothing passes through from req_valid.
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    if (r_state == S_XFER) begin
      mem_addr = r_addr + ADDRESS_WIDTH'(r_cnt);
      if (r_we) begin
        mem_we    = 1'b1;
        mem_wdata = r_wdata[{r_cnt, 3'b000} +: 8];
      end
    end
    if (r_state == S_RESP) begin
      resp_valid = 1'b1;
      resp_err   = r_err;
      if (!r_err && !r_we) resp_data = w_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-wide memory model and
// hand-computed expected results.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_addr, resp_data;
  logic        mem_we, resp_valid, resp_err;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [0:4095];
  int          wr_cnt = 0;
  int          rsp_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err)
  );

  assign mem_rdata = mem[mem_addr[11:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[11:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (resp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response; lat counts cycles after acceptance.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    rd = resp_data;
    er = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, w0;
  int          acc_n, acc_first, acc_second, rsp_n;
  logic [31:0] rsp_d [0:1];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h5A;
    mem[12'h200] = 8'h78; mem[12'h201] = 8'h56; mem[12'h202] = 8'h34; mem[12'h203] = 8'h12;
    mem[12'h300] = 8'h80; mem[12'h301] = 8'hFF;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Word store
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", lat, 5);
    chk("sw_data", rd, 32'd0);
    chk("sw_err", {31'd0, er}, 32'd0);
    chk("sw_mem", {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]}, 32'hDEADBEEF);
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);

    do_req(1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat);
    chk("lw_lat", lat, 5);
    chk("lw_data", rd, 32'h12345678);
    do_req(1'b0, 3'b001, 32'h202, 32'h0, rd, er, lat);
    chk("lh_lat", lat, 3);
    chk("lh_data", rd, 32'h00001234);
    do_req(1'b0, 3'b000, 32'h300, 32'h0, rd, er, lat);
    chk("lb_lat", lat, 2);
    chk("lb_data", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h300, 32'h0, rd, er, lat);
    chk("lbu_data", rd, 32'h00000080);
    do_req(1'b0, 3'b001, 32'h300, 32'h0, rd, er, lat);
    chk("lh_sext", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'b101, 32'h300, 32'h0, rd, er, lat);
    chk("lhu_data", rd, 32'h0000FF80);
    chk("lhu_err", {31'd0, er}, 32'd0);

    // Illegal requests: no memory access, immediate error response
    w0 = wr_cnt;
    do_req(1'b0, 3'b010, 32'h102, 32'h0, rd, er, lat);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_err", {31'd0, er}, 32'd1);
    chk("lw_mis_data", rd, 32'd0);
    do_req(1'b1, 3'b001, 32'h101, 32'h12345678, rd, er, lat);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 3'b111, 32'h0, 32'h0, rd, er, lat);
    chk("f3_111_lat", lat, 1);
    chk("f3_111_err", {31'd0, er}, 32'd1);
    chk("f3_111_data", rd, 32'd0);
    do_req(1'b1, 3'b100, 32'h0, 32'hFF, rd, er, lat);
    chk("sbu_err", {31'd0, er}, 32'd1);
    chk("illegal_no_writes", wr_cnt - w0, 0);

    // Reset after beat 1 of a word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h400; wdata = 32'hAABBCCDD;
    @(posedge clk); @(negedge clk); req_valid = 1'b0;
    w0 = rsp_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_resp", rsp_cnt - w0, 0);
    chk("abort_mem", {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]}, 32'h5A5ACCDD);
    do_req(1'b0, 3'b000, 32'h400, 32'h0, rd, er, lat);
    chk("post_abort_lb", rd, 32'hFFFFFFDD);
    chk("post_abort_lat", lat, 2);

    // Back-to-back byte loads with req_valid held; busy-time inputs must be ignored
    acc_n = 0; acc_first = -1; acc_second = -1; rsp_n = 0;
    rsp_d[0] = '0; rsp_d[1] = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = (i < 6); req_we = 1'b0; funct3 = 3'b000;
      case (i)
        0: addr = 32'h300;
        1: addr = 32'h200;
        2: addr = 32'h201;
        3: addr = 32'h203;
        default: addr = 32'h100;
      endcase
      #1;
      if (req_valid && req_ready) begin
        if (acc_n == 0) acc_first = i; else acc_second = i;
        acc_n++;
      end
      if (resp_valid) begin
        if (rsp_n < 2) rsp_d[rsp_n] = resp_data;
        rsp_n++;
      end
    end
    chk("b2b_accepts", acc_n, 2);
    chk("b2b_spacing", acc_second - acc_first, 3);
    chk("b2b_resps", rsp_n, 2);
    chk("b2b_data0", rsp_d[0], 32'hFFFFFF80);
    chk("b2b_data1", rsp_d[1], 32'h00000012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
